// File: rtl/kirsch_pkg.sv
// Shared definitions for the Kirsch compass-kernel pipeline: pixel width,
// coordinate sizing and the 3x3 window record passed between stages.
package kirsch_pkg;

  localparam int KIRSCH_DATA_W = 8;

  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [KIRSCH_DATA_W-1:0] p1;
    logic [KIRSCH_DATA_W-1:0] p2;
    logic [KIRSCH_DATA_W-1:0] p3;
    logic [KIRSCH_DATA_W-1:0] p4;
    logic [KIRSCH_DATA_W-1:0] p5;
    logic [KIRSCH_DATA_W-1:0] p6;
    logic [KIRSCH_DATA_W-1:0] p7;
    logic [KIRSCH_DATA_W-1:0] p8;
    logic [KIRSCH_DATA_W-1:0] p9;
  } kirsch_win_t;

endpackage

// File: rtl/kirsch_line_buffer.sv
// One image row of pixel storage. Read is combinational from the same address
// that is written on the edge, so the old contents are seen before the update.
module kirsch_line_buffer
  import kirsch_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int DATA_W = KIRSCH_DATA_W
) (
  input  logic                        clk,
  input  logic [coord_w(IMG_W)-1:0]   addr,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  output logic [DATA_W-1:0]           rd_data
);

  logic [DATA_W-1:0] mem [IMG_W];

  assign rd_data = mem[addr];

  // Contents are deliberately not reset; every location is rewritten before use.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/kirsch_window_gen.sv
// Raster-stream 3x3 window generator: two line buffers feed the right column
// of a 3x3 shift register; a window is flagged only for interior centres.
module kirsch_window_gen
  import kirsch_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = KIRSCH_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           pix_in,
  input  logic                        pix_valid,
  input  logic                        sof,
  output logic [DATA_W-1:0]           p1,
  output logic [DATA_W-1:0]           p2,
  output logic [DATA_W-1:0]           p3,
  output logic [DATA_W-1:0]           p4,
  output logic [DATA_W-1:0]           p5,
  output logic [DATA_W-1:0]           p6,
  output logic [DATA_W-1:0]           p7,
  output logic [DATA_W-1:0]           p8,
  output logic [DATA_W-1:0]           p9,
  output logic                        win_valid,
  output logic [coord_w(IMG_W)-1:0]   win_x,
  output logic [coord_w(IMG_H)-1:0]   win_y,
  output logic                        frame_done
);

  localparam int CW = coord_w(IMG_W);
  localparam int RW = coord_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     col, c_eff;
  logic [RW-1:0]     row, r_eff;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic              lb_we, last_col, last_row, interior;

  // sof forces the current pixel to (0,0) regardless of counter state
  assign c_eff    = sof ? '0 : col;
  assign r_eff    = sof ? '0 : row;
  assign last_col = (c_eff == COL_LAST);
  assign last_row = (r_eff == ROW_LAST);
  assign interior = (r_eff >= RW'(2)) && (c_eff >= CW'(2));
  assign lb_we    = pix_valid && !rst;

  kirsch_line_buffer #(.IMG_W(IMG_W), .DATA_W(DATA_W)) u_lb0 (
    .clk     (clk),
    .addr    (c_eff),
    .wr_en   (lb_we),
    .wr_data (pix_in),
    .rd_data (lb0_rd)
  );

  kirsch_line_buffer #(.IMG_W(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk     (clk),
    .addr    (c_eff),
    .wr_en   (lb_we),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      {p1, p2, p3, p4, p5, p6, p7, p8, p9} <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        {p1, p2, p3} <= {p2, p3, lb1_rd};
        {p4, p5, p6} <= {p5, p6, lb0_rd};
        {p7, p8, p9} <= {p8, p9, pix_in};
        win_valid    <= interior;
        frame_done   <= last_col && last_row;
        if (interior) begin
          win_x <= c_eff - CW'(1);
          win_y <= r_eff - RW'(1);
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : r_eff + RW'(1);
        end else begin
          col <= c_eff + CW'(1);
          row <= r_eff;
        end
      end
    end
  end

endmodule

// File: tb/tb_kirsch_window_gen.sv
// Bench for kirsch_window_gen on a 4x4 image; a frame-array reference model
// supplies the expected windows, coordinates and frame_done pulses.
module tb_kirsch_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, pix_valid, sof;
  logic [DW-1:0] pix_in;
  logic [DW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic          win_valid, frame_done;
  logic [1:0]    win_x, win_y;

  kirsch_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .p4         (p4),
    .p5         (p5),
    .p6         (p6),
    .p7         (p7),
    .p8         (p8),
    .p9         (p9),
    .win_valid  (win_valid),
    .win_x      (win_x),
    .win_y      (win_y),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state: position of the next pixel and the frame so far
  int            mr = 0, mc = 0;
  logic [DW-1:0] img [H][W];
  bit            zero_exp = 1'b1;
  bit            uniform = 1'b0;
  int            win_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d, input logic r);
    logic          e_valid, e_fd;
    logic [DW-1:0] e_win [9];
    logic [DW-1:0] o_win [9];
    int            e_x, e_y, y1;
    e_valid = 1'b0;
    e_fd    = 1'b0;
    e_x     = 0;
    e_y     = 0;
    foreach (e_win[k]) e_win[k] = '0;
    pix_valid = v; sof = s; pix_in = d; rst = r;
    if (r) begin
      mr = 0; mc = 0; zero_exp = 1'b1; win_seen = 0;
    end else if (v) begin
      zero_exp = 1'b0;
      if (s) begin
        mr = 0; mc = 0; win_seen = 0;
      end
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        e_valid = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e_win[i*3+j] = img[mr-2+i][mc-2+j];
        e_x = mc - 1;
        e_y = mr - 1;
      end
      e_fd = (mr == H-1) && (mc == W-1);
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    o_win = '{p1, p2, p3, p4, p5, p6, p7, p8, p9};
    if (win_valid === 1'b1) win_seen++;
    chk("win_valid", 32'(win_valid), 32'(e_valid));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    if (e_fd) chk("windows_per_frame", win_seen, 4);
    if (e_valid) begin
      for (int k = 0; k < 9; k++) chk($sformatf("p%0d", k+1), 32'(o_win[k]), 32'(e_win[k]));
      chk("win_x", 32'(win_x), e_x);
      chk("win_y", 32'(win_y), e_y);
      if (uniform) begin
        y1 = 5*(int'(p1) + int'(p4) + int'(p7))
           - 3*(int'(p2) + int'(p3) + int'(p6) + int'(p8) + int'(p9));
        chk("kirsch_west_y1", y1, 0);
      end
    end
    if (zero_exp) begin
      for (int k = 0; k < 9; k++) chk($sformatf("rst_p%0d", k+1), 32'(o_win[k]), 0);
      chk("rst_win_x", 32'(win_x), 0);
      chk("rst_win_y", 32'(win_y), 0);
    end
  endtask

  // mode 0: 16*r+c+off, mode 1: random pixels, mode 2: uniform 0x10
  task automatic send_frame(input int off, input bit gaps, input int mode);
    logic [DW-1:0] d;
    uniform = (mode == 2);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps)
          while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 8'($urandom), 1'b0);
        case (mode)
          1:       d = 8'($urandom);
          2:       d = 8'h10;
          default: d = 8'(16*r + c + off);
        endcase
        step(1'b1, (r == 0 && c == 0), d, 1'b0);
      end
    uniform = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // continuous frame, then the same image with random gaps
    send_frame(0, 1'b0, 0);
    send_frame(0, 1'b1, 0);

    // back-to-back frames, second offset by 0x80
    send_frame(0, 1'b0, 0);
    send_frame(8'h80, 1'b0, 0);

    // reset during row 2 (with valid and sof asserted alongside), then a new frame
    for (int k = 0; k < 9; k++) step(1'b1, (k == 0), 8'(16*(k/W) + k%W), 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b1);
    step(1'b1, 1'b0, 8'h66, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h77, 1'b0);
    send_frame(0, 1'b0, 0);

    // sof mid-frame at (2,1): the partial frame is abandoned
    for (int k = 0; k < 9; k++) step(1'b1, (k == 0), 8'(16*(k/W) + k%W), 1'b0);
    step(1'b1, 1'b1, 8'h40, 1'b0);
    for (int k = 1; k < W*H; k++) step(1'b1, 1'b0, 8'(8'h40 + k), 1'b0);
    send_frame(8'h20, 1'b1, 0);

    // random pixel data with gaps, then the uniform image into the west kernel
    for (int f = 0; f < 4; f++) send_frame(0, 1'b1, 1);
    send_frame(0, 1'b1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kirsch_window_gen.md
# kirsch_window_gen

Streaming 3x3 window generator that sits directly upstream of the Kirsch compass-kernel stages such as the west-kernel AMSG. It accepts a raster-order pixel stream, one pixel per valid beat, and buffers the two previous image rows. It emits registered neighbourhood pixels p1..p9 plus a one-cycle valid strobe for every interior window centre. Border centres (first/last row and column) produce no window.

## Interface
Parameters:
- IMG_W, 64: image width in pixels, ≥3
- IMG_H, 64: image height in pixels, ≥3
- DATA_W, 8: pixel width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pix_in  in  DATA_W  incoming pixel, raster order
- pix_valid  in  1  pix_in is valid this cycle; no backpressure
- sof  in  1  start of frame; qualified by pix_valid; marks pixel (0,0)
- p1, p2, p3  out  DATA_W  window top row (row r-2), left to right
- p4, p5, p6  out  DATA_W  window middle row (row r-1); p5 is the centre
- p7, p8, p9  out  DATA_W  window bottom row (row r); p9 is the newest pixel
- win_valid  out  1  p1..p9 hold a complete interior window
- win_x  out  $clog2(IMG_W)  centre column (c-1)
- win_y  out  $clog2(IMG_H)  centre row (r-1)
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position (r,c) of the pixel accepted this cycle.
- On accept (pix_valid=1):
  - read lb1[c] (row r-2) and lb0[c] (row r-1)
  - write lb1[c] <= lb0[c] and lb0[c] <= pix_in; line buffers are read-before-write
  - shift the window left one column; the new right column is {lb1[c], lb0[c], pix_in} into {p3, p6, p9}
- Column wrap: c=IMG_W-1 → c=0 and row+1. At (IMG_H-1, IMG_W-1) both counters wrap to 0 and frame_done pulses.
- sof=1 with pix_valid=1: the pixel is treated as (0,0) whatever the counter state. Counters continue from there. A mid-frame sof abandons the partial frame with no frame_done.
- win_valid is asserted on the cycle after accepting a pixel with r≥2 and c≥2. win_x=c-1, win_y=r-1. This yields exactly (IMG_W-2)*(IMG_H-2) windows per frame.
- Window columns left stale across a row boundary (c=0,1) are never flagged valid.
- pix_valid=0 holds all state. win_valid and frame_done are 0 that cycle; p1..p9 hold their values.
- No arithmetic on pixel data; values pass through unmodified, DATA_W bits throughout.
- Reset:
  - p1..p9, win_x, win_y, win_valid, frame_done, row and col all go to 0
  - line buffer contents are not cleared (they are never used before being rewritten)
  - a reset mid-frame discards the frame; the next accepted pixel is (0,0)
- rst has priority over pix_valid and sof in the same cycle.

## Timing
- Latency: 1 cycle from the accepting edge of pixel (r,c) to win_valid with p9 = that pixel.
- Throughput: one window per cycle sustained on interior pixels.
- frame_done asserts in the same cycle as the final window's win_valid.
- Line-buffer read is combinational or same-edge so that p3/p6 align with p9. A registered-read RAM needs a matching pixel delay internally; the external latency stays 1.

## Structure
- Package kirsch_pkg holds:
  - DATA_W default
  - coordinate width functions
  - a window struct type (nine DATA_W fields) shared with the downstream Kirsch kernel stages
- Sub-module kirsch_line_buffer: IMG_W x DATA_W, one read and one write per cycle, read-before-write. It is instantiated twice, for lb0 and lb1.
- The top level holds the counters, the window shift register and the valid/coordinate logic.

## Test plan
- IMG_W=4, IMG_H=4, pixel = 16*r+c, continuous valid, sof on the first pixel:
  - exactly 4 win_valid pulses
  - first window p1..p9 = 00,01,02,10,11,12,20,21,22, with win_x=1, win_y=1
  - last window has p5=22
  - frame_done pulses with the 4th window
- Same image with pix_valid toggled pseudo-randomly: identical window sequence and coordinates, and win_valid is never asserted on a cycle after pix_valid=0.
- Two back-to-back frames with values offset by 0x80 in the second: the second frame's first window has p1=80 and p9=A2. There is no window spanning the frame boundary.
- Assert rst during row 2 of a frame, then send a new frame with sof:
  - all outputs are 0 during and after reset
  - the new frame produces the correct 4 windows
- Assert sof mid-frame at (2,1): that pixel becomes (0,0), no frame_done for the abandoned frame, and the next full frame gives the correct windows.
- Uniform image value 0x10 with outputs fed to the Kirsch west stage: 5*48-3*80 = 0, so y1=0 on every valid window.
